// File: rtl/press_judge.sv
// Round and scoring controller for the Precision Button Press game.
// Optional build macro: PRESS_JUDGE_NEAR_HIT_EN enables near-hit judging of the LEDs adjacent to the target.
module press_judge #(
   parameter int unsigned TARGET_IDX     = 3,
   parameter int unsigned TIMEOUT_CYC    = 100_000_000,
   parameter int unsigned LIVES_INIT     = 3,
   parameter int unsigned HITS_PER_LEVEL = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [7:0] SEQ,
   output logic       PLAYING,
   output logic       HIT,
   output logic       NEAR,
   output logic       MISS,
   output logic [7:0] SCORE,
   output logic [1:0] LIVES,
   output logic [2:0] LEVEL,
   output logic       GAME_OVER
);

   localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned HW = $clog2(HITS_PER_LEVEL + 1);

   localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYC - 1);
   localparam logic [HW-1:0] HPL       = HW'(HITS_PER_LEVEL);
   localparam logic [1:0]    LIVES_RST = 2'(LIVES_INIT);
   localparam logic [7:0]    TGT_MASK  = 8'(1) << TARGET_IDX;

`ifdef PRESS_JUDGE_NEAR_HIT_EN
   // 8-bit truncation of the shifts drops the neighbour beyond either end, so no wrap 0<->7
   localparam logic [7:0] NEAR_LO = TGT_MASK >> 1;
   localparam logic [7:0] NEAR_HI = TGT_MASK << 1;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_PLAY,
      S_OVER
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    score_q, score_d;
   logic [1:0]    lives_q, lives_d;
   logic [2:0]    level_q, level_d;
   logic [HW-1:0] hitcnt_q, hitcnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          hit_q, hit_d;
   logic          miss_q, miss_d;
   logic          playing_q, playing_d;
   logic          game_over_q, game_over_d;
   logic [8:0]    score_sum;
   logic          judged;
   logic          lose;

`ifdef PRESS_JUDGE_NEAR_HIT_EN
   logic          near_q, near_d;
`endif

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      lives_d     = lives_q;
      level_d     = level_q;
      hitcnt_d    = hitcnt_q;
      timer_d     = timer_q;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      score_sum   = {1'b0, score_q};
      judged      = 1'b0;
      lose        = 1'b0;
`ifdef PRESS_JUDGE_NEAR_HIT_EN
      near_d      = 1'b0;
`endif

      case (state_q)
         S_IDLE, S_OVER: begin
            if (START) begin
               state_d  = S_ARM;
               score_d  = '0;
               lives_d  = LIVES_RST;
               level_d  = '0;
               hitcnt_d = '0;
            end
         end
         S_ARM: begin
            if (SEQ == '0) begin
               state_d = S_PLAY;
               timer_d = '0;
            end
         end
         S_PLAY: begin
            // a press on the final timeout cycle takes priority over the timeout
            if (SEQ != '0) begin
               judged = 1'b1;
               if (SEQ == TGT_MASK) begin
                  hit_d     = 1'b1;
                  score_sum = {1'b0, score_q} + 9'd2;
                  if (hitcnt_q + HW'(1) == HPL) begin
                     hitcnt_d = '0;
                     if (level_q != 3'd7) begin
                        level_d = level_q + 3'd1;
                     end
                  end else begin
                     hitcnt_d = hitcnt_q + HW'(1);
                  end
`ifdef PRESS_JUDGE_NEAR_HIT_EN
               end else if ((SEQ == NEAR_LO) || (SEQ == NEAR_HI)) begin
                  near_d    = 1'b1;
                  score_sum = {1'b0, score_q} + 9'd1;
`endif
               end else begin
                  lose = 1'b1;
               end
            end else if (timer_q == T_LAST) begin
               judged = 1'b1;
               lose   = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end

            if (lose) begin
               miss_d = 1'b1;
               if (lives_q != '0) begin
                  lives_d = lives_q - 2'd1;
               end
            end
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
            if (judged) begin
               state_d = (lives_d == '0) ? S_OVER : S_ARM;
            end
         end
         default: state_d = S_IDLE;
      endcase

      playing_d   = (state_d == S_ARM) || (state_d == S_PLAY);
      game_over_d = (state_d == S_OVER);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         score_q     <= '0;
         lives_q     <= LIVES_RST;
         level_q     <= '0;
         hitcnt_q    <= '0;
         timer_q     <= '0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         hitcnt_q    <= hitcnt_d;
         timer_q     <= timer_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         playing_q   <= playing_d;
         game_over_q <= game_over_d;
      end
   end

`ifdef PRESS_JUDGE_NEAR_HIT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         near_q <= 1'b0;
      end else begin
         near_q <= near_d;
      end
   end
   assign NEAR = near_q;
`else
   assign NEAR = 1'b0;
`endif

   assign PLAYING   = playing_q;
   assign HIT       = hit_q;
   assign MISS      = miss_q;
   assign SCORE     = score_q;
   assign LIVES     = lives_q;
   assign LEVEL     = level_q;
   assign GAME_OVER = game_over_q;

endmodule

// File: doc/press_judge.md
# press_judge

Round and scoring controller for the Precision Button Press game. Consumes the 8-bit captured sequence `SEQ` produced by the button/LED capture stage. `SEQ` is the LED one-hot pattern when the button is held, and zero otherwise. The controller judges each press against a target LED position and tracks score, lives, level and game-over. `LEVEL` feeds the LED sweep speed select; `SCORE`, `LIVES` and `GAME_OVER` feed the display path.

## Interface
- `TARGET_IDX`, default 3: bit index of the target LED in `SEQ` (0..7).
- `TIMEOUT_CYC`, default 100_000_000: cycles allowed per round before an automatic miss (≥2).
- `LIVES_INIT`, default 3: lives at reset and at game start (1..3).
- `HITS_PER_LEVEL`, default 4: exact hits needed per level increment (≥1).

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  start/restart request; level-sensitive and sampled each cycle.
- `SEQ`  in  8  captured LED pattern (0 = no press).
- `PLAYING`  out  1  high in ARM and PLAY.
- `HIT`  out  1  one-cycle pulse on an exact hit.
- `NEAR`  out  1  one-cycle pulse on a near hit (constant 0 unless `NEAR_HIT_EN` is defined).
- `MISS`  out  1  one-cycle pulse on a miss or timeout.
- `SCORE`  out  8  accumulated score, saturating.
- `LIVES`  out  2  remaining lives.
- `LEVEL`  out  3  difficulty level, saturating at 7.
- `GAME_OVER`  out  1  high in OVER.

## Operation
- States: IDLE, ARM, PLAY, OVER.
- IDLE: `START`=1 moves to ARM. On that transition `SCORE`←0, `LIVES`←`LIVES_INIT`, `LEVEL`←0, and the hit counter←0.
- ARM: waits for `SEQ`==0, so a held button cannot retrigger. Once `SEQ`==0, moves to PLAY with the timer cleared.
- PLAY: the timer increments each cycle while `SEQ`==0. The first cycle with `SEQ`≠0 is judged:
  - Exact hit: `SEQ` == 1<<`TARGET_IDX`. `SCORE`+=2, hit counter +1. When the hit counter reaches `HITS_PER_LEVEL`, `LEVEL`+=1 and the hit counter←0.
  - Near hit (macro only): `SEQ` is a single bit adjacent to the target (idx±1, with no wrap from 0 to 7). `SCORE`+=1; lives unchanged.
  - Anything else, including a non-one-hot pattern: `LIVES`-=1.
- Timeout: timer == `TIMEOUT_CYC`-1 with `SEQ`==0 is a miss; `LIVES`-=1.
- After a judgement: if `LIVES` becomes 0, go to OVER; otherwise go to ARM.
- OVER: `START`=1 reinitialises exactly as from IDLE and goes to ARM.
- `START` is ignored in ARM and PLAY.
- `SCORE` saturates at 255. `LEVEL` saturates at 7; once saturated, the hit counter still wraps. `LIVES` never underflows.

## Timing
- Reset values: state IDLE; `SCORE`=0, `LIVES`=`LIVES_INIT`, `LEVEL`=0; `HIT`/`NEAR`/`MISS`/`PLAYING`/`GAME_OVER`=0; timer and hit counter =0.
- `PLAYING` and `GAME_OVER` are registered state decodes and change on the edge of the state change.
- Judgement latency is one cycle. If `SEQ`≠0 is sampled at edge N, then at edge N+1:
  - exactly one of `HIT`/`NEAR`/`MISS` goes high for that single cycle;
  - `SCORE`/`LIVES`/`LEVEL` update;
  - the state becomes ARM or OVER.
- Timeout miss: `MISS` is high in the cycle after the timer reaches `TIMEOUT_CYC`-1. Total round length is `TIMEOUT_CYC` cycles of `SEQ`==0 in PLAY.
- A press sampled on the final timeout cycle is judged as a press, not a timeout.
- The timer width is $clog2(`TIMEOUT_CYC`); the timer never wraps.
- `RST` overrides everything, including a concurrent judgement or `START`.
- Reset mid-round discards the round and produces no pulse.

## Configuration
- `PRESS_JUDGE_NEAR_HIT_EN` defined: adjacent-LED presses are near hits (+1 score, `NEAR` pulse, no life lost).
- Not defined: adjacent presses are misses, and `NEAR` is tied to 0.

## Test plan
Bench parameters: `TARGET_IDX`=3, `TIMEOUT_CYC`=16, `LIVES_INIT`=3, `HITS_PER_LEVEL`=2.
- Reset, then `START` pulse, then `SEQ`=8'h08 held 5 cycles, then 0 → exactly one `HIT` pulse one cycle after the first 8'h08 sample; `SCORE`=2, `LIVES`=3; state returns to ARM and then PLAY.
- Two more exact hits → `LEVEL`=1 after the second hit overall and `SCORE`=6. Holding `SEQ`=8'h08 across rounds never double-counts.
- Never press after `START` → `MISS` exactly 16 cycles after PLAY entry. Repeat three times → `LIVES`=0 and `GAME_OVER`=1; `START` then restores `LIVES`=3, `SCORE`=0, `LEVEL`=0.
- `SEQ`=8'h10 → with macro: `NEAR` pulse, `SCORE`+1, `LIVES` unchanged; without macro: `MISS` pulse and `LIVES`-1. `SEQ`=8'h18 → `MISS` in both builds.
- Press `SEQ`=8'h08 on the 16th PLAY cycle (timer=15) → `HIT`, not `MISS`. Assert `RST` in the same cycle on a separate run → no pulse, all outputs at reset values.
- Preload `SCORE` to 254 via hits → the next hit yields 255, and further hits hold 255.
